mem_access_ctrl: RTL and testbench

//  Initiator side of the SEQ memory-stage interface. Decodes icode, then

---
 rtl/mem_access_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage initiator: decodes icode and runs one req/ack data-memory access per instruction.
// Optional address range check is enabled by defining MEM_ACCESS_ADDR_CHECK_EN.
module mem_access_ctrl #(
  parameter int MEM_WORDS   = 1024,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic [63:0] valM,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        mem_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             dec_access;
  logic             dec_we;
  logic [63:0]      dec_addr;
  logic [63:0]      dec_wdata;
  logic             range_bad;
  logic             accept;
  logic             expire;

  always_comb begin
    dec_access = 1'b1;
    dec_we     = 1'b0;
    dec_addr   = valE;
    dec_wdata  = 64'd0;
    case (icode)
      4'h4: begin dec_we = 1'b1; dec_wdata = valA; end
      4'h5: ;
      4'h8: begin dec_we = 1'b1; dec_wdata = valP; end
      4'h9: dec_addr = valA;
      4'hA: begin dec_we = 1'b1; dec_wdata = valA; end
      4'hB: ;
      default: dec_access = 1'b0;
    endcase
  end

`ifdef MEM_ACCESS_ADDR_CHECK_EN
  logic err_q;

  assign range_bad = (dec_addr >= 64'(MEM_WORDS));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      err_q <= 1'b0;
    else if (accept)
      err_q <= dec_access && range_bad;
  end

  assign mem_err = err_q;
`else
  assign range_bad = 1'b0;
  assign mem_err   = 1'b0;
`endif

  assign accept = (state == IDLE) && start;
  // Ack on the final allowed cycle takes priority over the abort.
  assign expire = (state == REQ) && !mem_ack && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_nxt = (dec_access && !range_bad) ? REQ : DONE;
      end
      REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack || expire)
          state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      timeout   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 64'd0;
      mem_wdata <= 64'd0;
      valM      <= 64'd0;
    end else if (accept) begin
      cnt     <= '0;
      timeout <= 1'b0;
      if (dec_access && !range_bad) begin
        mem_we    <= dec_we;
        mem_addr  <= dec_addr;
        mem_wdata <= dec_wdata;
      end
    end else if (state == REQ) begin
      if (mem_ack) begin
        if (!mem_we)
          valM <= mem_rdata;
      end else if (expire) begin
        timeout <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: reads, writes, no-access, timeout, reset abort, range check.
module tb_mem_access_ctrl;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valA, valE, valP;
  logic [63:0] valM;
  logic        busy, done, timeout, mem_err;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_access_ctrl #(.MEM_WORDS(1024), .TIMEOUT_CYC(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .icode     (icode),
    .valA      (valA),
    .valE      (valE),
    .valP      (valP),
    .valM      (valM),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .mem_err   (mem_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] ic, input logic [63:0] a,
                             input logic [63:0] e, input logic [63:0] p);
    icode = ic; valA = a; valE = e; valP = p;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc, dc;
    logic stable_bad;

    reset_n = 1'b0; start = 1'b0; icode = 4'h0;
    valA = 64'd0; valE = 64'd0; valP = 64'd0;
    mem_ack = 1'b0; mem_rdata = 64'd0;
    tick(); tick();
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_req",   64'(mem_req), 64'd0);
    chk("rst_valM",  valM, 64'd0);
    chk("rst_tmo",   64'(timeout), 64'd0);
    chk("rst_err",   64'(mem_err), 64'd0);
    chk("rst_addr",  mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_we",    64'(mem_we), 64'd0);
    reset_n = 1'b1;
    tick();

    // mrmovq, ack three cycles after the request appears
    pulse_start(4'h5, 64'h0, 64'h10, 64'h0);
    chk("t1_req",  64'(mem_req), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_we",   64'(mem_we), 64'd0);
    chk("t1_addr", mem_addr, 64'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_wait_req",  64'(mem_req), 64'd1);
      chk("t1_wait_done", 64'(done), 64'd0);
    end
    mem_ack = 1'b1; mem_rdata = 64'hDEAD;
    tick();
    mem_ack = 1'b0; mem_rdata = 64'd0;
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_req_off", 64'(mem_req), 64'd0);
    chk("t1_valM", valM, 64'hDEAD);
    tick();
    chk("t1_done_once", 64'(done), 64'd0);
    chk("t1_idle", 64'(busy), 64'd0);

    // call, immediate ack: done at T+2
    pulse_start(4'h8, 64'h99, 64'h20, 64'h44);
    chk("t2_we",    64'(mem_we), 64'd1);
    chk("t2_addr",  mem_addr, 64'h20);
    chk("t2_wdata", mem_wdata, 64'h44);
    chk("t2_done_early", 64'(done), 64'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_valM_kept", valM, 64'hDEAD);
    tick();

    // ret reads at valA; nop needs no access
    pulse_start(4'h9, 64'h30, 64'h77, 64'h0);
    chk("t3_addr", mem_addr, 64'h30);
    chk("t3_we",   64'(mem_we), 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'h1234;
    tick();
    mem_ack = 1'b0; mem_rdata = 64'd0;
    chk("t3_valM", valM, 64'h1234);
    tick();
    pulse_start(4'h1, 64'h5, 64'h6, 64'h7);
    chk("t3_nop_req",  64'(mem_req), 64'd0);
    chk("t3_nop_done", 64'(done), 64'd1);
    chk("t3_nop_valM", valM, 64'h1234);
    tick();
    chk("t3_nop_idle", 64'(busy), 64'd0);

    // rmmovq never acked: 16 request cycles then abort
    pulse_start(4'h4, 64'h55, 64'h40, 64'h0);
    rc = 0; dc = 0; stable_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) begin
        rc++;
        if (mem_addr !== 64'h40 || mem_wdata !== 64'h55 || mem_we !== 1'b1)
          stable_bad = 1'b1;
      end
      if (done) dc++;
      tick();
    end
    chk("t4_req_cycles", 64'(rc), 64'd16);
    chk("t4_done_cnt",   64'(dc), 64'd1);
    chk("t4_timeout",    64'(timeout), 64'd1);
    chk("t4_stable",     64'(stable_bad), 64'd0);

    // stray ack while idle has no effect
    mem_ack = 1'b1; mem_rdata = 64'hFFFF;
    tick();
    mem_ack = 1'b0; mem_rdata = 64'd0;
    chk("stray_done", 64'(done), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_valM", valM, 64'h1234);

    // next start clears timeout
    pulse_start(4'h5, 64'h0, 64'h8, 64'h0);
    chk("t4_tmo_clr", 64'(timeout), 64'd0);
    mem_ack = 1'b1; mem_rdata = 64'hBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 64'd0;
    chk("t4_valM", valM, 64'hBEEF);
    tick();

    // start while busy is ignored, then reset mid-request
    pulse_start(4'h5, 64'h0, 64'h60, 64'h0);
    pulse_start(4'h4, 64'h11, 64'h99, 64'h0);
    chk("t5_addr_kept", mem_addr, 64'h60);
    chk("t5_we_kept",   64'(mem_we), 64'd0);
    chk("t5_req",       64'(mem_req), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_req",  64'(mem_req), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_addr", mem_addr, 64'd0);
    chk("t5_rst_valM", valM, 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 5; i++) begin
      if (done) dc++;
      tick();
    end
    chk("t5_no_done", 64'(dc), 64'd0);

    // pushq at address MEM_WORDS
    pulse_start(4'hA, 64'h77, 64'd1024, 64'h0);
`ifdef MEM_ACCESS_ADDR_CHECK_EN
    chk("t6_err",  64'(mem_err), 64'd1);
    chk("t6_req",  64'(mem_req), 64'd0);
    chk("t6_done", 64'(done), 64'd1);
    tick();
`else
    chk("t6_err",   64'(mem_err), 64'd0);
    chk("t6_req",   64'(mem_req), 64'd1);
    chk("t6_addr",  mem_addr, 64'd1024);
    chk("t6_wdata", mem_wdata, 64'h77);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t6_done", 64'(done), 64'd1);
    tick();
`endif
    chk("t6_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
